// File: rtl/count_ones_sched_pkg.sv
// Shared types and constants for the count-ones scheduler.
// Holds the FSM state encoding and the per-job watchdog limit.
package count_ones_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_CLR,
        WAIT_DONE,
        RESPOND
    } sched_state_t;

    function automatic int timeout_cycles(input int width);
        return width * 5;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
// The pointer only advances when a grant is actually taken (en && any req).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] last_grant;

    always_comb begin
        int k;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        k         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            k = int'(last_grant) + off;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!grant_vld && req[k]) begin
                grant_vld = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

    // Reset to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (en && grant_vld) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/count_ones_sched.sv
// Shares one count-ones core among NUM_REQ requesters with round-robin
// arbitration and a per-job watchdog that returns an error on core hang.
module count_ones_sched
    import count_ones_sched_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  INPUT_WIDTH    = 32,
    parameter int  TIMEOUT_CYCLES = timeout_cycles(INPUT_WIDTH),
    localparam int OUTPUT_WIDTH   = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0]   req_in,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [OUTPUT_WIDTH-1:0]               resp_out,
    output logic                                  resp_err,
    output logic                                  busy,
    output logic                                  core_go,
    output logic [INPUT_WIDTH-1:0]                core_in,
    input  logic                                  core_done,
    input  logic [OUTPUT_WIDTH-1:0]               core_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t          state;
    logic [IDX_W-1:0]      idx;
    logic [NUM_REQ-1:0]    idx_oh;
    logic [INPUT_WIDTH-1:0] operand;
    logic [INPUT_WIDTH-1:0] sel_operand;
    logic [WD_W-1:0]       wd;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // AND-OR select of the granted operand using the one-hot grant.
    always_comb begin
        sel_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_operand = sel_operand | (req_in[i] & {INPUT_WIDTH{grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            operand  <= '0;
            wd       <= '0;
            resp_out <= '0;
            resp_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        idx     <= grant_idx;
                        operand <= sel_operand;
                        state   <= START;
                    end
                end
                START: begin
                    // WAIT_CLR is the first counted watchdog cycle.
                    wd    <= WD_W'(1);
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // core_done may still be stale from the previous job here.
                    wd    <= wd + WD_W'(1);
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        resp_out <= core_out;
                        resp_err <= 1'b0;
                        state    <= RESPOND;
                    end else if (wd >= WD_W'(TIMEOUT_CYCLES)) begin
                        resp_out <= '0;
                        resp_err <= 1'b1;
                        state    <= RESPOND;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign idx_oh     = NUM_REQ'(1) << idx;
    assign busy       = (state != IDLE);
    assign core_go    = (state == START);
    assign core_in    = operand;
    assign req_ack    = (state == START)   ? idx_oh : '0;
    assign resp_valid = (state == RESPOND) ? idx_oh : '0;

endmodule

// File: tb/tb_count_ones_sched.sv
// Bench for count_ones_sched: table of single jobs plus arbitration,
// watchdog and mid-job reset sequences, checked through a scoreboard.
module tb_count_ones_sched;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int OW = 6;
    localparam int TO = 160;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NR-1:0]          req = '0;
    logic [NR-1:0][W-1:0]   req_in = '0;
    logic [NR-1:0]          req_ack;
    logic [NR-1:0]          resp_valid;
    logic [OW-1:0]          resp_out;
    logic                   resp_err;
    logic                   busy;
    logic                   core_go;
    logic [W-1:0]           core_in;
    logic                   core_done = 1'b0;
    logic [OW-1:0]          core_out = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int core_dly = 4;
    bit core_hang = 1'b0;

    count_ones_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_in     (req_in),
        .req_ack    (req_ack),
        .resp_valid (resp_valid),
        .resp_out   (resp_out),
        .resp_err   (resp_err),
        .busy       (busy),
        .core_go    (core_go),
        .core_in    (core_in),
        .core_done  (core_done),
        .core_out   (core_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done drops one cycle after it sees go, then rises core_dly
    // cycles after go and stays high (stale) until the next job.
    logic go_d = 1'b0;
    logic running = 1'b0;
    int   cnt = 0;
    always @(posedge clk) begin
        go_d <= core_go;
        if (go_d) begin
            core_done <= 1'b0;
            running   <= 1'b0;
            if (!core_hang) begin
                if (core_dly <= 2) begin
                    core_done <= 1'b1;
                    core_out  <= OW'($countones(core_in));
                end else begin
                    running <= 1'b1;
                    cnt     <= core_dly - 2;
                end
            end
        end else if (running) begin
            if (cnt <= 1) begin
                core_done <= 1'b1;
                core_out  <= OW'($countones(core_in));
                running   <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [W-1:0] op;
        logic [OW-1:0] out;
        bit          err;
        int          lat;
        int          t;
    } exp_t;

    exp_t exp_q[$];
    exp_t infl[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push_exp(input int r, input logic [W-1:0] op, input bit hang, input int dly);
        exp_t e;
        e.idx = r;
        e.op  = op;
        e.out = hang ? '0 : OW'($countones(op));
        e.err = hang;
        e.lat = hang ? TO + 1 : dly + 1;
        e.t   = 0;
        exp_q.push_back(e);
    endtask

    // Scoreboard: acks pop the expected grant order, responses pop in-flight jobs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ack != '0) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ack got=%b want=none", req_ack);
                end else begin
                    exp_t e;
                    logic [63:0] oh;
                    e = exp_q.pop_front();
                    oh = '0; oh[e.idx] = 1'b1;
                    check("ack_idx", 64'(req_ack), oh);
                    check("core_in", 64'(core_in), 64'(e.op));
                    e.t = cyc;
                    infl.push_back(e);
                end
            end
            if (resp_valid != '0) begin
                if (infl.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp got=%b want=none", resp_valid);
                end else begin
                    exp_t e;
                    logic [63:0] oh;
                    e = infl.pop_front();
                    oh = '0; oh[e.idx] = 1'b1;
                    check("resp_idx", 64'(resp_valid), oh);
                    check("resp_out", 64'(resp_out), 64'(e.out));
                    check("resp_err", 64'(resp_err), 64'(e.err));
                    check("latency", 64'(cyc - e.t), 64'(e.lat));
                end
            end
        end
    end

    a_go: assert property (@(posedge clk) disable iff (!rst_n) core_go |=> !core_go)
        else begin failures++; $display("FAIL assert_core_go got=2_cycles want=1_cycle"); end
    a_ack1h: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ack))
        else begin failures++; $display("FAIL assert_ack_onehot got=%b", req_ack); end
    a_rsp1h: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(resp_valid))
        else begin failures++; $display("FAIL assert_resp_onehot got=%b", resp_valid); end
    a_ackreq: assert property (@(posedge clk) disable iff (!rst_n) (req_ack & ~req) == '0)
        else begin failures++; $display("FAIL assert_ack_without_req ack=%b req=%b", req_ack, req); end

    // Drive mask; drop each acked bit a cycle later (drop mode) or hold all
    // until n_acks grants have been seen (hold mode). Bounded by budget cycles.
    task automatic run_jobs(input logic [NR-1:0] mask, input int n_acks, input bit hold, input int budget);
        logic [NR-1:0] drop;
        int acks, n;
        bit stop, fin;
        drop = '0; acks = 0; n = 0; stop = 1'b0; fin = 1'b0;
        req = mask;
        while (n < budget && !fin) begin
            @(negedge clk);
            n++;
            if (!hold) req = req & ~drop;
            else if (stop) req = '0;
            drop = req_ack;
            if (req_ack != '0) begin
                acks++;
                if (acks >= n_acks) stop = 1'b1;
            end
            if (req == '0 && !busy && exp_q.size() == 0 && infl.size() == 0) fin = 1'b1;
        end
        if (!fin) begin
            checks++; failures++;
            $display("FAIL run_timeout got=%0d_cycles want=<%0d pending_exp=%0d pending_resp=%0d",
                     n, budget, exp_q.size(), infl.size());
            req = '0;
            exp_q.delete();
            infl.delete();
        end
    endtask

    typedef struct {
        int           r;
        logic [W-1:0] op;
        int           dly;
        bit           hang;
        logic [OW-1:0] out;
        bit           err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [W-1:0] ops [4];
        bit got;

        tbl[0] = '{0, 32'hFFFF_FFFF, 33, 1'b0, 6'd32, 1'b0};
        tbl[1] = '{1, 32'h0000_0000,  2, 1'b0, 6'd0,  1'b0};
        tbl[2] = '{2, 32'h8000_0001,  5, 1'b0, 6'd2,  1'b0};
        tbl[3] = '{3, 32'h0F0F_0F0F,  3, 1'b0, 6'd16, 1'b0};
        tbl[4] = '{1, 32'hFFFF_FFFE, 10, 1'b0, 6'd31, 1'b0};
        tbl[5] = '{0, 32'h1234_5678,  4, 1'b0, 6'd13, 1'b0};
        tbl[6] = '{2, 32'h0000_0000,  4, 1'b1, 6'd0,  1'b1};
        tbl[7] = '{3, 32'hAAAA_AAAA,  6, 1'b0, 6'd16, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({req_ack, resp_valid, resp_out, resp_err, busy, core_go, core_in}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Single-job table
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            req_in[tbl[i].r] = tbl[i].op;
            core_dly  = tbl[i].dly;
            core_hang = tbl[i].hang;
            e.idx = tbl[i].r;
            e.op  = tbl[i].op;
            e.out = tbl[i].out;
            e.err = tbl[i].err;
            e.lat = tbl[i].hang ? TO + 1 : tbl[i].dly + 1;
            e.t   = 0;
            exp_q.push_back(e);
            run_jobs(NR'(1) << tbl[i].r, 1, 1'b0, 400);
        end
        core_hang = 1'b0;

        // All four held: order 0,1,2,3 then 0 again
        ops[0] = 32'h0; ops[1] = 32'h1; ops[2] = 32'h3; ops[3] = 32'h7;
        core_dly = 4;
        for (int i = 0; i < NR; i++) begin
            req_in[i] = ops[i];
            push_exp(i, ops[i], 1'b0, core_dly);
        end
        push_exp(0, ops[0], 1'b0, core_dly);
        run_jobs(4'b1111, 5, 1'b1, 200);

        // Grant 2, then 0101 wraps to 0 before 2
        core_dly = 3;
        req_in[2] = 32'h3;
        push_exp(2, 32'h3, 1'b0, core_dly);
        run_jobs(4'b0100, 1, 1'b0, 100);
        req_in[0] = 32'hF;
        req_in[2] = 32'hFF;
        push_exp(0, 32'hF, 1'b0, core_dly);
        push_exp(2, 32'hFF, 1'b0, core_dly);
        run_jobs(4'b0101, 2, 1'b0, 100);

        // Reset during WAIT_DONE abandons the job
        core_hang = 1'b1;
        req_in[2] = 32'h0000_00F0;
        push_exp(2, 32'h0000_00F0, 1'b1, core_dly);
        req = 4'b0100;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ack[2]) got = 1'b1;
        end
        check("rst_job_ack", 64'(got), 64'd1);
        repeat (5) @(negedge clk);
        check("busy_mid_job", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 64'({req_ack, resp_valid, resp_out, resp_err, busy, core_go, core_in}), 64'd0);
        exp_q.delete();
        infl.delete();
        repeat (2) @(negedge clk);
        check("held_reset_outputs", 64'({req_ack, resp_valid, resp_out, resp_err, busy, core_go, core_in}), 64'd0);
        core_hang = 1'b0;
        core_dly  = 5;
        req_in[1] = 32'h7;
        push_exp(1, 32'h7, 1'b0, core_dly);
        push_exp(2, 32'h0000_00F0, 1'b0, core_dly);
        rst_n = 1'b1;
        run_jobs(4'b0110, 2, 1'b0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d_cycles want=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
